// File: rtl/demux1x2_pipe_pkg.sv
// rtl/demux1x2_pipe_pkg.sv - shared operand width and route select encoding
package demux1x2_pipe_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic {
    ROUTE_ALU = 1'b0,
    ROUTE_MDU = 1'b1
  } route_e;

endpackage

// File: rtl/demux1x2_pipe_slot.sv
// rtl/demux1x2_pipe_slot.sv - one-entry valid/data register slot (pipe_slot)
module demux1x2_pipe_slot
  import demux1x2_pipe_pkg::*;
#(
  parameter int WIDTH = RV_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  // Pass-through: a full slot can take a new word in the cycle it drains.
  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1x2_pipe.sv
// rtl/demux1x2_pipe.sv - registered 1-to-2 operand demux, ALU / MUL-DIV steering
module demux1x2_pipe
  import demux1x2_pipe_pkg::*;
#(
  parameter int WIDTH = RV_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] output1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] output2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic             busy
);

  logic sel_mdu;
  logic can_load1;
  logic can_load2;
  logic accept;

  assign sel_mdu  = (route_e'(enable) == ROUTE_MDU);
  assign in_ready = !flush && (sel_mdu ? can_load2 : can_load1);
  assign accept   = in_valid && in_ready;
  assign busy     = out1_valid | out2_valid;

  demux1x2_pipe_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (accept && !sel_mdu),
    .load_data (in_data),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (output1),
    .can_load  (can_load1)
  );

  demux1x2_pipe_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (accept && sel_mdu),
    .load_data (in_data),
    .ready     (out2_ready),
    .valid     (out2_valid),
    .data      (output2),
    .can_load  (can_load2)
  );

endmodule

// File: tb/tb_demux1x2_pipe.sv
// tb/tb_demux1x2_pipe.sv - directed self-checking bench for demux1x2_pipe
module tb_demux1x2_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] output1;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] output2;
  logic        out2_valid;
  logic        out2_ready;
  logic        busy;

  int compared;
  int mismatched;

  demux1x2_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .output1    (output1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .output2    (output2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_data    = 32'h0;
    enable     = 1'b0;
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    #1;
    check("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    check("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
    check("rst_output1", output1, 32'h0);
    check("rst_output2", output2, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #12 rst_n = 1'b1;
    tick();

    // Step 1: word to ALU slot
    in_valid = 1'b1; in_data = 32'h0000_1234; enable = 1'b0;
    #1 check("s1_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("s1_out1_valid", {31'b0, out1_valid}, 32'd1);
    check("s1_output1", output1, 32'h0000_1234);
    check("s1_out2_valid", {31'b0, out2_valid}, 32'd0);
    check("s1_busy", {31'b0, busy}, 32'd1);

    // Step 2: slot2 stalls
    in_valid = 1'b1; in_data = 32'hAAAA_0001; enable = 1'b1;
    #1 check("s2_in_ready_first", {31'b0, in_ready}, 32'd1);
    tick();
    check("s2_out2_valid", {31'b0, out2_valid}, 32'd1);
    check("s2_output2", output2, 32'hAAAA_0001);
    in_data = 32'hAAAA_0002;
    #1 check("s2_in_ready_second", {31'b0, in_ready}, 32'd0);
    tick();
    check("s2_output2_held", output2, 32'hAAAA_0001);
    check("s2_output1_held", output1, 32'h0000_1234);

    // Step 3: ALU path flows while slot2 stalls (slot1 drains same cycle)
    out1_ready = 1'b1;
    in_data = 32'h0000_0005; enable = 1'b0;
    #1 check("s3_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("s3_output1", output1, 32'h0000_0005);
    check("s3_out1_valid", {31'b0, out1_valid}, 32'd1);
    check("s3_output2_unchanged", output2, 32'hAAAA_0001);
    check("s3_out2_valid_unchanged", {31'b0, out2_valid}, 32'd1);

    // Step 4: pass-through refill and back-to-back stream
    in_data = 32'h0000_0007;
    #1 check("s4_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("s4_out1_valid", {31'b0, out1_valid}, 32'd1);
    check("s4_output1", output1, 32'h0000_0007);
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h0000_0100 + i;
      tick();
      check($sformatf("s4_stream_%0d", i), output1, 32'h0000_0100 + i);
      check($sformatf("s4_stream_valid_%0d", i), {31'b0, out1_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out1_ready = 1'b0;
    tick();
    check("s4_output1_last", output1, 32'h0000_0107);

    // Step 5: flush with both slots full
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0BAD; enable = 1'b0;
    #1 check("s5_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("s5_out1_valid", {31'b0, out1_valid}, 32'd0);
    check("s5_out2_valid", {31'b0, out2_valid}, 32'd0);
    check("s5_busy", {31'b0, busy}, 32'd0);
    check("s5_output1_held", output1, 32'h0000_0107);

    // Refill both, then drain both in the same cycle
    in_valid = 1'b1; in_data = 32'h0000_0011; enable = 1'b0;
    tick();
    in_data = 32'h0000_0022; enable = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rf_output1", output1, 32'h0000_0011);
    check("rf_output2", output2, 32'h0000_0022);
    check("rf_busy", {31'b0, busy}, 32'd1);
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
    out1_ready = 1'b0; out2_ready = 1'b0;
    check("dr_out1_valid", {31'b0, out1_valid}, 32'd0);
    check("dr_out2_valid", {31'b0, out2_valid}, 32'd0);

    // Step 6: async reset mid-cycle with both slots full
    in_valid = 1'b1; in_data = 32'h0000_0033; enable = 1'b0;
    tick();
    in_data = 32'h0000_0044; enable = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s6_pre_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_out1_valid", {31'b0, out1_valid}, 32'd0);
    check("s6_out2_valid", {31'b0, out2_valid}, 32'd0);
    check("s6_output1", output1, 32'h0);
    check("s6_output2", output2, 32'h0);
    check("s6_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
